// File: rtl/spram_multibank_if.sv
// Request/response and power-control bundle for the multi-bank single-port RAM.
// The master drives requests and power controls; the slave returns status and read data.
interface spram_multibank_if #(
   parameter int DATA_W  = 16,
   parameter int LANE_W  = 4,
   parameter int BANKS   = 4,
   parameter int BANK_AW = 14
);
   localparam int MASK_W = DATA_W / LANE_W;
   localparam int ADDR_W = $clog2(BANKS) + BANK_AW;

   logic              REQ;
   logic              WREN;
   logic [ADDR_W-1:0] ADDRESS;
   logic [DATA_W-1:0] DATAIN;
   logic [MASK_W-1:0] MASKWREN;
   logic [BANKS-1:0]  SLEEP;
   logic [BANKS-1:0]  POWEROFF;
   logic              READY;
   logic              ERR;
   logic              RVALID;
   logic [DATA_W-1:0] DATAOUT;
   logic [BANKS-1:0]  BANK_ON;

   modport master (
      output REQ, WREN, ADDRESS, DATAIN, MASKWREN, SLEEP, POWEROFF,
      input  READY, ERR, RVALID, DATAOUT, BANK_ON
   );

   modport slave (
      input  REQ, WREN, ADDRESS, DATAIN, MASKWREN, SLEEP, POWEROFF,
      output READY, ERR, RVALID, DATAOUT, BANK_ON
   );
endinterface

// File: rtl/spram_multibank.sv
// Banked single-port RAM with per-bank ON/SLEEP/WAKE/OFF power FSMs and lane write masks.
// Reads return RD_LAT cycles after acceptance; READY is combinational, refused requests pulse ERR.
module spram_multibank #(
   parameter int DATA_W      = 16,
   parameter int LANE_W      = 4,
   parameter int BANKS       = 4,
   parameter int BANK_AW     = 14,
   parameter int WAKE_CYCLES = 3,
   parameter int RD_LAT      = 1
) (
   input logic         CLOCK,
   input logic         RESET_N,
   spram_multibank_if.slave bus
);
   localparam int MASK_W = DATA_W / LANE_W;
   localparam int BSEL_W = (BANKS > 1) ? $clog2(BANKS) : 1;
   localparam int CNT_W  = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

   typedef enum logic [1:0] {ST_ON, ST_SLEEP, ST_WAKE, ST_OFF} pwr_state_t;

   logic [BSEL_W-1:0]  bank_sel;
   logic [BANK_AW-1:0] word_sel;
   logic [BANKS-1:0]   bank_on;
   logic [DATA_W-1:0]  rdata [BANKS];
   logic               accept;
   logic               rd_accept;
   logic               rd_v1;
   logic [BSEL_W-1:0]  rd_bsel1;
   logic [DATA_W-1:0]  rdata_sel;
   logic [DATA_W-1:0]  dout_q;
   logic               err_q;

   assign bank_sel  = BSEL_W'(bus.ADDRESS >> BANK_AW);
   assign word_sel  = bus.ADDRESS[BANK_AW-1:0];
   // Gating with RESET_N keeps reset from both reporting READY and touching memory.
   assign accept    = bus.REQ & bank_on[bank_sel] & RESET_N;
   assign rd_accept = accept & ~bus.WREN;

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      pwr_state_t        state;
      logic [CNT_W-1:0]  cnt;
      logic [DATA_W-1:0] mem [2**BANK_AW];
      logic [DATA_W-1:0] rd_q;
      logic              hit;

      assign hit = accept && (bank_sel == BSEL_W'(b));

      // POWEROFF low overrides every other transition.
      always_ff @(posedge CLOCK or negedge RESET_N) begin
         if (!RESET_N) begin
            state <= ST_ON;
            cnt   <= '0;
         end else if (!bus.POWEROFF[b]) begin
            state <= ST_OFF;
         end else begin
            case (state)
               ST_ON: begin
                  if (bus.SLEEP[b]) state <= ST_SLEEP;
               end
               ST_SLEEP: begin
                  if (!bus.SLEEP[b]) begin
                     state <= ST_WAKE;
                     cnt   <= WAKE_LOAD;
                  end
               end
               ST_WAKE: begin
                  if (bus.SLEEP[b])    state <= ST_SLEEP;
                  else if (cnt == '0)  state <= ST_ON;
                  else                 cnt   <= cnt - CNT_W'(1);
               end
               ST_OFF: begin
                  state <= ST_WAKE;
                  cnt   <= WAKE_LOAD;
               end
            endcase
         end
      end

      always_ff @(posedge CLOCK) begin
         if (hit) begin
            if (bus.WREN) begin
               for (int i = 0; i < MASK_W; i++) begin
                  if (bus.MASKWREN[i])
                     mem[word_sel][i*LANE_W +: LANE_W] <= bus.DATAIN[i*LANE_W +: LANE_W];
               end
            end else begin
               rd_q <= mem[word_sel];
            end
         end
      end

      assign bank_on[b] = (state == ST_ON);
      assign rdata[b]   = rd_q;
   end

   assign rdata_sel = rdata[rd_bsel1];

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         rd_v1    <= 1'b0;
         rd_bsel1 <= '0;
         dout_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         rd_v1 <= rd_accept;
         if (rd_accept) rd_bsel1 <= bank_sel;
         err_q <= bus.REQ & ~accept;
         if (rd_v1) dout_q <= rdata_sel;
      end
   end

   // dout_q doubles as the hold register (RD_LAT=1) and the second pipe stage (RD_LAT=2).
   if (RD_LAT == 2) begin : g_lat2
      logic rd_v2;
      always_ff @(posedge CLOCK or negedge RESET_N) begin
         if (!RESET_N) rd_v2 <= 1'b0;
         else          rd_v2 <= rd_v1;
      end
      assign bus.RVALID  = rd_v2;
      assign bus.DATAOUT = dout_q;
   end else begin : g_lat1
      assign bus.RVALID  = rd_v1;
      assign bus.DATAOUT = rd_v1 ? rdata_sel : dout_q;
   end

   assign bus.READY   = accept;
   assign bus.ERR     = err_q;
   assign bus.BANK_ON = bank_on;
endmodule

// File: tb/tb_spram_multibank.sv
// Directed bench driving one RD_LAT=1 and one RD_LAT=2 instance with identical stimulus;
// read expectations are queued at issue time and retired when each instance responds.
module tb_spram_multibank;
   localparam int WAKE = 3;

   logic        CLOCK;
   logic        RESET_N;
   logic        req;
   logic        wren;
   logic [15:0] address;
   logic [15:0] datain;
   logic [3:0]  maskwren;
   logic [3:0]  sleep;
   logic [3:0]  poweroff;

   spram_multibank_if #(.DATA_W(16), .LANE_W(4), .BANKS(4), .BANK_AW(14)) if1 ();
   spram_multibank_if #(.DATA_W(16), .LANE_W(4), .BANKS(4), .BANK_AW(14)) if2 ();

   assign if1.REQ = req;      assign if2.REQ = req;
   assign if1.WREN = wren;    assign if2.WREN = wren;
   assign if1.ADDRESS = address;   assign if2.ADDRESS = address;
   assign if1.DATAIN = datain;     assign if2.DATAIN = datain;
   assign if1.MASKWREN = maskwren; assign if2.MASKWREN = maskwren;
   assign if1.SLEEP = sleep;       assign if2.SLEEP = sleep;
   assign if1.POWEROFF = poweroff; assign if2.POWEROFF = poweroff;

   spram_multibank #(.DATA_W(16), .LANE_W(4), .BANKS(4), .BANK_AW(14),
                     .WAKE_CYCLES(WAKE), .RD_LAT(1)) dut1 (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .bus(if1.slave));

   spram_multibank #(.DATA_W(16), .LANE_W(4), .BANKS(4), .BANK_AW(14),
                     .WAKE_CYCLES(WAKE), .RD_LAT(2)) dut2 (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .bus(if2.slave));

   typedef struct {
      logic [15:0] data;
      int          due;
   } rec_t;

   rec_t        q1[$];
   rec_t        q2[$];
   logic [15:0] model [int];
   bit          err_exp [int];
   logic [15:0] last1 = '0;
   logic [15:0] last2 = '0;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;
   bit          mon_en = 1'b0;
   rec_t        mon_e;
   logic        exp_v;

   initial begin
      CLOCK = 1'b0;
      forever #5 CLOCK = ~CLOCK;
   end

   always @(posedge CLOCK) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                         input logic [3:0] m);
      logic [15:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (m[i]) r[i*4 +: 4] = d[i*4 +: 4];
      return r;
   endfunction

   // Response monitor: RVALID timing, data, hold behaviour and ERR pulses, every cycle.
   always @(negedge CLOCK) begin
      if (mon_en) begin
         exp_v = (q1.size() > 0) && (q1[0].due == cyc);
         check("rvalid_lat1", if1.RVALID, exp_v);
         if (exp_v) begin
            mon_e = q1.pop_front();
            last1 = mon_e.data;
         end
         check("dataout_lat1", if1.DATAOUT, last1);

         exp_v = (q2.size() > 0) && (q2[0].due == cyc);
         check("rvalid_lat2", if2.RVALID, exp_v);
         if (exp_v) begin
            mon_e = q2.pop_front();
            last2 = mon_e.data;
         end
         check("dataout_lat2", if2.DATAOUT, last2);

         check("err_lat1", if1.ERR, err_exp.exists(cyc));
         check("err_lat2", if2.ERR, err_exp.exists(cyc));
      end
   end

   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic bon(input logic [3:0] exp);
      @(negedge CLOCK);
      check("bank_on_lat1", if1.BANK_ON, exp);
      check("bank_on_lat2", if2.BANK_ON, exp);
      step();
   endtask

   task automatic acc(input bit wr, input int bank, input int word, input logic [15:0] d,
                      input logic [3:0] m, input bit rdy);
      int   a;
      rec_t e;
      a        = (bank << 14) | word;
      req      = 1'b1;
      wren     = wr;
      address  = a[15:0];
      datain   = d;
      maskwren = m;
      @(negedge CLOCK);
      check("ready_lat1", if1.READY, rdy);
      check("ready_lat2", if2.READY, rdy);
      if (!rdy) begin
         err_exp[cyc+1] = 1'b1;
      end else if (wr) begin
         model[a] = merge(model.exists(a) ? model[a] : 16'hxxxx, d, m);
      end else begin
         e.data = model[a];
         e.due  = cyc + 1;
         q1.push_back(e);
         e.due  = cyc + 2;
         q2.push_back(e);
      end
      step();
      req = 1'b0;
   endtask

   initial begin
      RESET_N  = 1'b0;
      req      = 1'b1;
      wren     = 1'b0;
      address  = '0;
      datain   = '0;
      maskwren = '0;
      sleep    = '0;
      poweroff = '1;
      repeat (2) step();

      // Outputs under reset, with a request held active.
      @(negedge CLOCK);
      check("rst_ready", if1.READY, 1'b0);
      check("rst_err", if1.ERR, 1'b0);
      check("rst_rvalid_lat1", if1.RVALID, 1'b0);
      check("rst_rvalid_lat2", if2.RVALID, 1'b0);
      check("rst_dataout_lat1", if1.DATAOUT, 16'h0000);
      check("rst_dataout_lat2", if2.DATAOUT, 16'h0000);
      check("rst_bank_on", if1.BANK_ON, 4'hF);
      step();
      req     = 1'b0;
      RESET_N = 1'b1;
      mon_en  = 1'b1;
      step();

      // Masked write merge, then no-op mask write.
      acc(1, 0, 5, 16'hABCD, 4'hF, 1);
      acc(1, 0, 5, 16'h1234, 4'h2, 1);
      acc(0, 0, 5, 16'h0000, 4'h0, 1);
      step();
      acc(1, 0, 5, 16'hFFFF, 4'h0, 1);
      acc(0, 0, 5, 16'h0000, 4'h0, 1);
      step();

      // Back-to-back writes and reads of bank 3 words 0..3.
      for (int i = 0; i < 4; i++) acc(1, 3, i, 16'(i), 4'hF, 1);
      for (int i = 0; i < 4; i++) acc(0, 3, i, 16'h0000, 4'h0, 1);
      repeat (3) step();

      // Read-before-write on the same word, then write followed by read.
      acc(0, 3, 0, 16'h0000, 4'h0, 1);
      acc(1, 3, 0, 16'h7777, 4'hF, 1);
      acc(0, 3, 0, 16'h0000, 4'h0, 1);
      acc(1, 1, 9, 16'h1111, 4'hF, 1);
      step();

      // Bank 1 sleep: refused read and write, then timed wake.
      sleep[1] = 1'b1;
      step();
      bon(4'b1101);
      acc(0, 1, 9, 16'h0000, 4'h0, 0);
      acc(1, 1, 9, 16'hFFFF, 4'hF, 0);
      sleep[1] = 1'b0;
      for (int i = 0; i < WAKE + 1; i++) bon(4'b1101);
      bon(4'b1111);
      acc(0, 1, 9, 16'h0000, 4'h0, 1);

      // Wake aborted by a new sleep request restarts the full wake delay.
      sleep[1] = 1'b1;
      step();
      sleep[1] = 1'b0;
      step();
      sleep[1] = 1'b1;
      step();
      sleep[1] = 1'b0;
      for (int i = 0; i < WAKE + 1; i++) bon(4'b1101);
      bon(4'b1111);

      // Bank 2 powered off during wake, then restored and rewritten.
      sleep[2] = 1'b1;
      step();
      sleep[2] = 1'b0;
      step();
      bon(4'b1011);
      poweroff[2] = 1'b0;
      step();
      bon(4'b1011);
      acc(0, 2, 7, 16'h0000, 4'h0, 0);
      poweroff[2] = 1'b1;
      for (int i = 0; i < WAKE + 1; i++) bon(4'b1011);
      bon(4'b1111);
      acc(1, 2, 7, 16'h5A5A, 4'hF, 1);
      acc(0, 2, 7, 16'h0000, 4'h0, 1);
      step();

      // Reset while a read is in flight cancels it; memory survives.
      acc(0, 0, 5, 16'h0000, 4'h0, 1);
      RESET_N = 1'b0;
      q1.delete();
      q2.delete();
      last1 = '0;
      last2 = '0;
      bon(4'b1111);
      RESET_N = 1'b1;
      step();
      acc(0, 0, 5, 16'h0000, 4'h0, 1);
      acc(0, 3, 0, 16'h0000, 4'h0, 1);
      acc(0, 2, 7, 16'h0000, 4'h0, 1);
      acc(0, 1, 9, 16'h0000, 4'h0, 1);
      repeat (4) step();

      check("drain_lat1", q1.size(), 0);
      check("drain_lat2", q2.size(), 0);
      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
